alu_bank_array: RTL and testbench

Parametrised N-bank ALU, the successor to the fixed 4-bank ALU.
- Each bank has its own valid/ready request port, an in-order request FIFO, a fixed-latency execute FSM, and a one-cycle response pulse.
- Banks are fully independent and share only clock and reset.
- Sits behind the command distributor. Results go to the per-bank scoreboard/consumer.

---
 rtl/alu_bank_array_if.sv | 24 ++
 rtl/alu_bank_array.sv | 191 +++++++++++++++++++
 tb/tb_alu_bank_array.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_bank_array_if.sv
// Request/response bundle for alu_bank_array.
// master: command distributor side, slave: the ALU bank array.
interface alu_bank_array_if #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_BANKS-1:0]        in_valid;
  logic [NUM_BANKS-1:0]        in_ready;
  logic [2*NUM_BANKS-1:0]      in_cmd;
  logic [DATA_W*NUM_BANKS-1:0] in_data1;
  logic [DATA_W*NUM_BANKS-1:0] in_data2;
  logic [2*NUM_BANKS-1:0]      out_resp;
  logic [DATA_W*NUM_BANKS-1:0] out_data;

  modport master (
    output in_valid, in_cmd, in_data1, in_data2,
    input  in_ready, out_resp, out_data
  );

  modport slave (
    input  in_valid, in_cmd, in_data1, in_data2,
    output in_ready, out_resp, out_data
  );
endinterface

// File: rtl/alu_bank_array.sv
// N-bank ALU: each bank has an in-order request FIFO, a fixed-latency
// execute FSM and a one-cycle response pulse. Banks share only clock/reset.
// Optional build macro ALU_STATS_EN adds per-bank response/overflow counters
// on ports stat_count and stat_ovf.
//
// Per-bank FSM states:
//   state  | meaning
//   IDLE   | waiting for a queued request; pops the FIFO head when non-empty
//   EXEC   | counting down the latency; registers the result at count 0
//   RESP   | response pulse cycle; otherwise acts exactly like IDLE
module alu_bank_array #(
  parameter int NUM_BANKS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 4
) (
  input  logic               clock,
  input  logic               reset,
  alu_bank_array_if.slave    bus
`ifdef ALU_STATS_EN
  ,
  output logic [16*NUM_BANKS-1:0] stat_count,
  output logic [16*NUM_BANKS-1:0] stat_ovf
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_ADD = 2'd1;
  localparam logic [1:0] CMD_SUB = 2'd2;
  localparam logic [1:0] CMD_AND = 2'd3;

  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_OVF  = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 2);

  logic                        rdy_en;
  logic [NUM_BANKS-1:0]        in_ready_v;
  logic [2*NUM_BANKS-1:0]      out_resp_v;
  logic [DATA_W*NUM_BANKS-1:0] out_data_v;

  assign bus.in_ready = in_ready_v;
  assign bus.out_resp = out_resp_v;
  assign bus.out_data = out_data_v;

  // Keeps in_ready low in reset and raises it on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0]        fifo_cmd [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_a   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_b   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [1:0]        state;
    logic [3:0]        lat_cnt;
    logic [1:0]        op_cmd;
    logic [DATA_W-1:0] op_a, op_b;
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              ready, push, pop, fire;
    logic [1:0]        req_cmd;

    assign req_cmd = bus.in_cmd[2*b +: 2];
    // Full FIFO refuses even when a pop happens in the same cycle.
    assign ready = rdy_en && (count < CNT_W'(FIFO_DEPTH));
    assign push  = bus.in_valid[b] && ready && (req_cmd != CMD_NOP);
    assign pop   = ((state == S_IDLE) || (state == S_RESP)) && (count != '0);
    assign fire  = (state == S_EXEC) && (lat_cnt == 4'd0);

    assign in_ready_v[b]               = ready;
    assign out_resp_v[2*b +: 2]        = resp_q;
    assign out_data_v[DATA_W*b +: DATA_W] = data_q;

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
      if (push) begin
        fifo_cmd[wr_ptr] <= req_cmd;
        fifo_a[wr_ptr]   <= bus.in_data1[DATA_W*b +: DATA_W];
        fifo_b[wr_ptr]   <= bus.in_data2[DATA_W*b +: DATA_W];
      end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Result and signed-overflow detection from the operand registers.
    always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op_cmd)
        CMD_ADD: begin
          alu_res = op_a + op_b;
          alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != op_a[DATA_W-1]);
        end
        CMD_SUB: begin
          alu_res = op_a - op_b;
          alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                    (alu_res[DATA_W-1] != op_a[DATA_W-1]);
        end
        CMD_AND: alu_res = op_a & op_b;
        default: alu_res = '0;
      endcase
    end

    // Execute FSM; out_resp is a one-cycle pulse, out_data holds its value.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state   <= S_IDLE;
        lat_cnt <= '0;
        op_cmd  <= CMD_NOP;
        op_a    <= '0;
        op_b    <= '0;
        resp_q  <= RSP_NONE;
        data_q  <= '0;
      end else begin
        resp_q <= RSP_NONE;
        case (state)
          S_IDLE, S_RESP: begin
            if (pop) begin
              op_cmd  <= fifo_cmd[rd_ptr];
              op_a    <= fifo_a[rd_ptr];
              op_b    <= fifo_b[rd_ptr];
              lat_cnt <= LAT_LOAD;
              state   <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
          S_EXEC: begin
            if (fire) begin
              resp_q <= alu_ovf ? RSP_OVF : RSP_OK;
              data_q <= alu_res;
              state  <= S_RESP;
            end else begin
              lat_cnt <= lat_cnt - 4'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

`ifdef ALU_STATS_EN
    logic [15:0] resp_cnt, ovf_cnt;

    // Saturating counts of issued responses and of OVERFLOW responses.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        resp_cnt <= '0;
        ovf_cnt  <= '0;
      end else if (fire) begin
        if (resp_cnt != 16'hFFFF)            resp_cnt <= resp_cnt + 16'd1;
        if (alu_ovf && ovf_cnt != 16'hFFFF)  ovf_cnt  <= ovf_cnt + 16'd1;
      end
    end

    assign stat_count[16*b +: 16] = resp_cnt;
    assign stat_ovf[16*b +: 16]   = ovf_cnt;
`endif
  end

endmodule

// File: tb/tb_alu_bank_array.sv
// Directed bench for alu_bank_array (4 banks, 32-bit, depth 4, latency 4).
module tb_alu_bank_array;

  localparam int NB = 4;
  localparam int DW = 32;

  logic clock;
  logic reset;
  int   total;
  int   passed;

  alu_bank_array_if #(.NUM_BANKS(NB), .DATA_W(DW)) bus();

`ifdef ALU_STATS_EN
  logic [16*NB-1:0] stat_count;
  logic [16*NB-1:0] stat_ovf;
`endif

  alu_bank_array #(
    .NUM_BANKS(NB), .DATA_W(DW), .FIFO_DEPTH(4), .LATENCY(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef ALU_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_ovf(stat_ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int b, input logic [1:0] cmd,
                       input logic [31:0] a, input logic [31:0] bb);
    bus.in_valid[b]         = 1'b1;
    bus.in_cmd[2*b +: 2]    = cmd;
    bus.in_data1[32*b +: 32] = a;
    bus.in_data2[32*b +: 32] = bb;
  endtask

  task automatic idle_inputs();
    bus.in_valid = '0;
    bus.in_cmd   = '0;
    bus.in_data1 = '0;
    bus.in_data2 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    total++; if (bus.in_ready !== 4'h0) $display("FAIL reset_ready got=%h exp=0", bus.in_ready); else passed++;
    total++; if (bus.out_resp !== 8'h00) $display("FAIL reset_resp got=%h exp=0", bus.out_resp); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL reset_data got=%h exp=0", bus.out_data); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.in_ready !== 4'h0) $display("FAIL ready_before_edge got=%h exp=0", bus.in_ready); else passed++;
    tick();
    total++; if (bus.in_ready !== 4'hF) $display("FAIL ready_after_edge got=%h exp=f", bus.in_ready); else passed++;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    drive(0, 2'd1, 32'd1, 32'd2);
    tick();
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus.out_resp !== 8'h00) $display("FAIL midreset_resp got=%h exp=0", bus.out_resp); else passed++;
    total++; if (bus.in_ready !== 4'h0) $display("FAIL midreset_ready got=%h exp=0", bus.in_ready); else passed++;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    total++; if (bus.in_ready !== 4'hF) $display("FAIL midreset_ready_release got=%h exp=f", bus.in_ready); else passed++;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_resp !== 8'h00) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0) $display("FAIL midreset_no_resp got=%b exp=0", seen); else passed++;
    total++; if (bus.out_data !== '0) $display("FAIL midreset_data got=%h exp=0", bus.out_data); else passed++;
  endtask

  task automatic test_latency();
    drive(2, 2'd1, 32'h0000_0005, 32'h0000_0007);
    tick();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        total++; if (bus.out_resp[5:4] !== 2'd1) $display("FAIL lat_resp_e4 got=%0d exp=1", bus.out_resp[5:4]); else passed++;
        total++; if (bus.out_data[95:64] !== 32'h0000_000C) $display("FAIL lat_data got=%h exp=0000000c", bus.out_data[95:64]); else passed++;
      end else begin
        total++; if (bus.out_resp !== 8'h00) $display("FAIL lat_resp_e%0d got=%h exp=0", k, bus.out_resp); else passed++;
      end
    end
    total++; if (bus.out_data[95:64] !== 32'h0000_000C) $display("FAIL lat_data_hold got=%h exp=0000000c", bus.out_data[95:64]); else passed++;
  endtask

  task automatic test_overflow();
    logic [1:0]  r [2];
    logic [31:0] d [2];
    int          cy [2];
    int          got;
    r[0] = 0; r[1] = 0; d[0] = 0; d[1] = 0; cy[0] = 0; cy[1] = 0;
    drive(1, 2'd1, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    drive(1, 2'd2, 32'h8000_0000, 32'h0000_0001);
    tick();
    idle_inputs();
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (bus.out_resp[3:2] != 2'd0) begin
        r[got]  = bus.out_resp[3:2];
        d[got]  = bus.out_data[63:32];
        cy[got] = c;
        got++;
      end
      tick();
    end
    total++; if (got !== 2) $display("FAIL ovf_count got=%0d exp=2", got); else passed++;
    total++; if (r[0] !== 2'd2) $display("FAIL ovf_add_resp got=%0d exp=2", r[0]); else passed++;
    total++; if (d[0] !== 32'h8000_0000) $display("FAIL ovf_add_data got=%h exp=80000000", d[0]); else passed++;
    total++; if (r[1] !== 2'd2) $display("FAIL ovf_sub_resp got=%0d exp=2", r[1]); else passed++;
    total++; if (d[1] !== 32'h7FFF_FFFF) $display("FAIL ovf_sub_data got=%h exp=7fffffff", d[1]); else passed++;
    total++; if (cy[1] - cy[0] !== 4) $display("FAIL ovf_spacing got=%0d exp=4", cy[1] - cy[0]); else passed++;
  endtask

  task automatic test_full_fifo();
    int acc, nresp, last_cyc, low_at;
    bit rdy;
    acc = 0; nresp = 0; last_cyc = 0; low_at = -1;
    for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
      if (acc < 6) drive(3, 2'd3, 32'hFFFF_FFF0 | 32'(acc), 32'h0000_00FF);
      else         bus.in_valid[3] = 1'b0;
      rdy = bus.in_ready[3] && (acc < 6);
      tick();
      if (rdy) acc++;
      if (low_at < 0 && acc < 6 && bus.in_ready[3] === 1'b0) low_at = acc;
      if (bus.out_resp[7:6] != 2'd0) begin
        total++; if (bus.out_resp[7:6] !== 2'd1) $display("FAIL full_resp%0d got=%0d exp=1", nresp, bus.out_resp[7:6]); else passed++;
        total++; if (bus.out_data[127:96] !== (32'h0000_00F0 | 32'(nresp))) $display("FAIL full_data%0d got=%h exp=%h", nresp, bus.out_data[127:96], 32'h0000_00F0 | 32'(nresp)); else passed++;
        if (nresp > 0) begin
          total++; if (cyc - last_cyc !== 4) $display("FAIL full_spacing%0d got=%0d exp=4", nresp, cyc - last_cyc); else passed++;
        end
        last_cyc = cyc;
        nresp++;
      end
    end
    idle_inputs();
    total++; if (low_at !== 5) $display("FAIL full_ready_drop got=%0d exp=5", low_at); else passed++;
    total++; if (nresp !== 6) $display("FAIL full_resp_count got=%0d exp=6", nresp); else passed++;
    repeat (4) tick();
  endtask

  task automatic test_nop_independence();
    int bank0_resps;
    drive(0, 2'd0, 32'h0000_0001, 32'h0000_0001);
    tick();
    total++; if (bus.in_ready[0] !== 1'b1) $display("FAIL nop_ready got=%b exp=1", bus.in_ready[0]); else passed++;
    for (int b = 0; b < NB; b++) drive(b, 2'd2, 32'd9, 32'd4);
    tick();
    idle_inputs();
    bank0_resps = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (bus.out_resp[1:0] != 2'd0) bank0_resps++;
      if (k == 4) begin
        total++; if (bus.out_resp !== 8'b0101_0101) $display("FAIL indep_resp got=%b exp=01010101", bus.out_resp); else passed++;
        total++; if (bus.out_data !== {4{32'd5}}) $display("FAIL indep_data got=%h exp=%h", bus.out_data, {4{32'd5}}); else passed++;
      end else begin
        total++; if (bus.out_resp !== 8'h00) $display("FAIL indep_quiet_e%0d got=%h exp=0", k, bus.out_resp); else passed++;
      end
    end
    total++; if (bank0_resps !== 1) $display("FAIL nop_bank0_resps got=%0d exp=1", bank0_resps); else passed++;
  endtask

`ifdef ALU_STATS_EN
  task automatic test_stats();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
    total++; if (stat_count[15:0] !== 16'd0) $display("FAIL stats_init_count got=%0d exp=0", stat_count[15:0]); else passed++;
    drive(0, 2'd1, 32'd1, 32'd1);
    tick();
    drive(0, 2'd1, 32'h7FFF_FFFF, 32'd1);
    tick();
    drive(0, 2'd3, 32'hF0F0_F0F0, 32'hFFFF_0000);
    tick();
    idle_inputs();
    repeat (20) tick();
    total++; if (stat_count[15:0] !== 16'd3) $display("FAIL stats_count got=%0d exp=3", stat_count[15:0]); else passed++;
    total++; if (stat_ovf[15:0] !== 16'd1) $display("FAIL stats_ovf got=%0d exp=1", stat_ovf[15:0]); else passed++;
    reset = 1'b0;
    #1;
    total++; if (stat_count[15:0] !== 16'd0) $display("FAIL stats_count_reset got=%0d exp=0", stat_count[15:0]); else passed++;
    total++; if (stat_ovf[15:0] !== 16'd0) $display("FAIL stats_ovf_reset got=%0d exp=0", stat_ovf[15:0]); else passed++;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick();
  endtask
`endif

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_reset_mid_op();
    test_latency();
    repeat (3) tick();
    test_overflow();
    repeat (3) tick();
    test_full_fifo();
    test_nop_independence();
`ifdef ALU_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
